// File: rtl/opensync_cf_pkg.sv
// Shared constants and frame classification helper for the opensync correctionfield updater.
package opensync_cf_pkg;

   localparam logic [15:0] PTP_ETHERTYPE   = 16'h88F7;
   localparam logic [15:0] PCF_ETHERTYPE   = 16'h891D;
   localparam logic [3:0]  PTP_EVENT_MAX   = 4'd3;
   localparam logic [10:0] ETH_TYPE_OFS    = 11'd12;
   localparam logic [10:0] PTP_MSGTYPE_OFS = 11'd14;
   localparam logic [10:0] BYTE_CNT_MAX    = 11'd2047;

   typedef enum logic [1:0] {
      CLS_OTHER = 2'd0,
      CLS_PTP   = 2'd1,
      CLS_PCF   = 2'd2
   } cf_class_e;

   // Only PTP event messages (Sync, Delay_Req, Pdelay_Req, Pdelay_Resp) carry a correctionField we update.
   function automatic cf_class_e cf_classify(input logic [15:0] etype,
                                             input logic [15:0] ptpType,
                                             input logic [15:0] pcfType,
                                             input logic [3:0]  msgType);
      cf_class_e cls;
      cls = CLS_OTHER;
      if ((etype == ptpType) && (msgType <= PTP_EVENT_MAX)) begin
         cls = CLS_PTP;
      end else if (etype == pcfType) begin
         cls = CLS_PCF;
      end
      return cls;
   endfunction

endpackage

// File: rtl/cf_byte_delay_line.sv
// Fixed-latency {valid,byte} shift register; also exposes the stage ahead of the tail so a
// consumer can load per-frame state in the same edge the first byte reaches the tail.
module cf_byte_delay_line #(
   parameter int DEPTH = 16
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_wr,
   input  logic [7:0] iv_data,
   output logic       o_wr,
   output logic [7:0] ov_data,
   output logic       o_pre_wr
);

   logic [DEPTH-1:0]      r_wr;
   logic [DEPTH-1:0][7:0] r_data;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr   <= '0;
         r_data <= '0;
      end else begin
         r_wr   <= {r_wr[DEPTH-2:0], i_wr};
         r_data <= {r_data[DEPTH-2:0], iv_data};
      end
   end

   assign o_wr     = r_wr[DEPTH-1];
   assign ov_data  = r_data[DEPTH-1];
   assign o_pre_wr = r_wr[DEPTH-2];

endmodule

// File: rtl/cf_update_classify.sv
// Frame classifier ahead of the correctionfield residence-time calculator: timestamps, classifies
// and delays each frame. Define CF_CLASSIFY_STAT_EN to add per-class output frame counters.
module cf_update_classify
   import opensync_cf_pkg::*;
#(
   parameter int          DELAY_BYTES   = 16,
   parameter logic [15:0] PTP_ETHERTYPE = opensync_cf_pkg::PTP_ETHERTYPE,
   parameter logic [15:0] PCF_ETHERTYPE = opensync_cf_pkg::PCF_ETHERTYPE
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [7:0]  iv_data,
   input  logic        i_data_wr,
   input  logic [63:0] iv_local_time,
   output logic [7:0]  ov_data,
   output logic        o_data_wr,
   output logic [63:0] ov_receive_time,
   output logic        o_cf_update_flag,
`ifdef CF_CLASSIFY_STAT_EN
   output logic        o_tsn_or_tte,
   output logic [31:0] ov_ptp_cnt,
   output logic [31:0] ov_pcf_cnt,
   output logic [31:0] ov_other_cnt
`else
   output logic        o_tsn_or_tte
`endif
);

   logic        r_armed;
   logic [10:0] r_cnt;
   logic [15:0] r_etype;
   logic [63:0] r_pend_time;
   logic        r_pend_flag;
   logic        r_pend_tsn;

   logic        w_in_wr;
   logic        w_pre_wr;
   logic        w_out_load;
   cf_class_e   w_cls;

   // A frame already in flight when reset releases is ignored until i_data_wr drops.
   assign w_in_wr = i_data_wr & r_armed;
   assign w_cls   = cf_classify(r_etype, PTP_ETHERTYPE, PCF_ETHERTYPE, iv_data[3:0]);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_armed     <= 1'b0;
         r_cnt       <= '0;
         r_etype     <= '0;
         r_pend_time <= '0;
         r_pend_flag <= 1'b0;
         r_pend_tsn  <= 1'b0;
      end else begin
         if (!i_data_wr) begin
            r_armed <= 1'b1;
         end
         if (!w_in_wr) begin
            r_cnt <= '0;
         end else if (r_cnt != BYTE_CNT_MAX) begin
            r_cnt <= r_cnt + 11'd1;
         end
         if (w_in_wr) begin
            if (r_cnt == 11'd0) begin
               r_pend_time <= iv_local_time;
               r_pend_flag <= 1'b0;
               r_pend_tsn  <= 1'b0;
               r_etype     <= '0;
            end
            if (r_cnt == ETH_TYPE_OFS) begin
               r_etype[15:8] <= iv_data;
            end
            if (r_cnt == ETH_TYPE_OFS + 11'd1) begin
               r_etype[7:0] <= iv_data;
            end
            if (r_cnt == PTP_MSGTYPE_OFS) begin
               r_pend_flag <= (w_cls != CLS_OTHER);
               r_pend_tsn  <= (w_cls == CLS_PTP);
            end
         end
      end
   end

   cf_byte_delay_line #(
      .DEPTH(DELAY_BYTES)
   ) u_delay (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wr     (w_in_wr),
      .iv_data  (iv_data),
      .o_wr     (o_data_wr),
      .ov_data  (ov_data),
      .o_pre_wr (w_pre_wr)
   );

   // Load on the edge where the first byte enters the tail, so metadata is already stable at output byte 0.
   assign w_out_load = w_pre_wr & ~o_data_wr;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ov_receive_time  <= '0;
         o_cf_update_flag <= 1'b0;
         o_tsn_or_tte     <= 1'b0;
      end else if (w_out_load) begin
         ov_receive_time  <= r_pend_time;
         o_cf_update_flag <= r_pend_flag;
         o_tsn_or_tte     <= r_pend_tsn;
      end
   end

`ifdef CF_CLASSIFY_STAT_EN
   logic [31:0] r_ptp_cnt;
   logic [31:0] r_pcf_cnt;
   logic [31:0] r_other_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_ptp_cnt   <= '0;
         r_pcf_cnt   <= '0;
         r_other_cnt <= '0;
      end else if (w_out_load) begin
         if (r_pend_flag && r_pend_tsn) begin
            r_ptp_cnt <= r_ptp_cnt + 32'd1;
         end else if (r_pend_flag) begin
            r_pcf_cnt <= r_pcf_cnt + 32'd1;
         end else begin
            r_other_cnt <= r_other_cnt + 32'd1;
         end
      end
   end

   assign ov_ptp_cnt   = r_ptp_cnt;
   assign ov_pcf_cnt   = r_pcf_cnt;
   assign ov_other_cnt = r_other_cnt;
`else
`endif

endmodule
